cbus_clint: RTL and testbench
=============================

// Module: cbus_clint
// PURPOSE
//  Address-routing stage on the CBus, directly downstream of the CBus arbiter
//  and upstream of the memory model. It serves CLINT registers (msip, mtimecmp,
//  mtime) locally, forwards all other transactions unchanged to memory, and
//  generates the core's timer and software interrupts (trint, swint).
// PARAMETERS
//  CLINT_BASE   32'h0200_0000  base of the locally served region
//  CLINT_SIZE   32'h0001_0000  region size in bytes (power of two)
//  TICK_DIV     1              clk cycles per mtime increment (>=1)
// PORTS
//  clk       in   1        single clock, rising edge
//  reset     in   1        asynchronous, ACTIVE-LOW reset
//  ireq      in   cbus_req_t   request from arbiter (valid,is_write,size,addr,strobe,data,len,burst)
//  iresp     out  cbus_resp_t  response to arbiter (ready,last,data)
//  oreq      out  cbus_req_t   request to memory
//  oresp     in   cbus_resp_t  response from memory
//  exint_in  in   1        external interrupt from memory model
//  trint     out  1        timer interrupt: mtime >= mtimecmp (unsigned)
//  swint     out  1        software interrupt: msip[0]
//  exint     out  1        = exint_in, registered one cycle
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF,
//   msip=0, tick counter=0, oreq='0, iresp='0, trint=0, swint=0, exint=0.
//  Register map (offset from CLINT_BASE, 8-byte aligned accesses):
//   0x0000 msip (bit0 only writable, rest read 0); 0x4000 mtimecmp; 0xBFF8 mtime.
//   Other offsets in region: read 0, writes ignored, still acknowledged.
//  FSM states: IDLE, PASS, LOCAL.
//   IDLE: ireq.valid & addr in [BASE,BASE+SIZE) -> LOCAL; ireq.valid otherwise -> PASS.
//    Route decided on the first valid cycle only; latched until last beat.
//   PASS: oreq=ireq, iresp=oresp combinationally; leave to IDLE on
//    oresp.ready & oresp.last. Outside PASS, oreq.valid=0.
//   LOCAL: iresp.ready=1 every cycle in LOCAL; one beat per cycle, beat count
//    len+1; iresp.last=1 on final beat, then -> IDLE. First beat the cycle after
//    entry (1-cycle latency). iresp.data = selected register (read value sampled
//    that cycle). Writes apply strobe bytewise on each beat where ready=1.
//  mtime: increments by 1 when tick counter reaches TICK_DIV-1 (counter wraps
//   to 0); wraps 2^64-1 -> 0. Software write to mtime in same cycle as an
//   increment: write wins, increment dropped, tick counter unaffected.
//  trint/swint registered: updated the cycle after mtime/mtimecmp/msip change.
//  Arbiter guarantees ireq stable until last; ireq.valid dropping mid-LOCAL
//   aborts to IDLE without side effects on remaining beats.
//  Reset asserted mid-transaction: FSM to IDLE immediately, no partial write
//   committed beyond beats already acknowledged.
// STRUCTURE
//  Shared package (common): CLINT_BASE/offset constants, msip/mtimecmp/mtime
//   offset localparams, clint_state_t enum {IDLE,PASS,LOCAL}; reuse existing
//   cbus_req_t/cbus_resp_t.
//  One sub-module: clint_regs (mtime/tick counter, mtimecmp, msip, strobe
//   write, read mux, trint/swint compare); top holds FSM and routing.
// TESTING
//  1 Reset release, no traffic -> trint=0 swint=0, mtime reads 0 then counts
//    +1/cycle (TICK_DIV=1); oreq.valid=0.
//  2 Read 0x8000_0000 len=0 -> forwarded verbatim; iresp mirrors memory data,
//    FSM back to IDLE after last.
//  3 Write mtimecmp=0x20, strobe 0xFF -> ack 1 cycle later, last=1; trint
//    rises the cycle after mtime reaches 0x20; write 0xFFFF.. -> trint=0.
//  4 Write msip=1 -> swint=1 next cycle; write 0 -> swint=0; byte strobe
//    0x02 on msip -> no change.
//  5 Write mtime=64'hFFFF_FFFF_FFFF_FFFF -> next increment wraps to 0; write
//    coinciding with tick -> written value held, no +1.
//  6 Burst read len=3 to CLINT -> 4 beats, ready each cycle, last on 4th;
//    assert reset on beat 2 -> all outputs 0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/cbus_clint_pkg.sv
// Shared CBus types plus CLINT register-map constants and the FSM state enum.
package cbus_clint_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    LOCAL = 2'd2
  } clint_state_t;

  function automatic logic [63:0] strobe_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cbus_clint_regs.sv
// CLINT register file: mtime with tick divider, mtimecmp, msip, read mux and
// registered timer/software interrupt outputs.
module clint_regs
  import cbus_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [12:0] word_i,
  input  logic [7:0]  strobe_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        trint_o,
  output logic        swint_o
);

  localparam logic [31:0] TICK_MAX = 32'(TICK_DIV - 1);

  logic [31:0] tick_q, tick_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        trint_q, swint_q;
  logic        sel_msip, sel_cmp, sel_mtime, tick;

  assign sel_msip  = (word_i == MSIP_OFF[15:3]);
  assign sel_cmp   = (word_i == MTIMECMP_OFF[15:3]);
  assign sel_mtime = (word_i == MTIME_OFF[15:3]);
  assign tick      = (tick_q == TICK_MAX);

  // A software write to mtime overrides the increment; the divider keeps running.
  always_comb begin
    tick_d     = tick ? 32'd0 : tick_q + 32'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (we_i) begin
      if (sel_mtime) mtime_d = strobe_merge(mtime_q, wdata_i, strobe_i);
      if (sel_cmp) mtimecmp_d = strobe_merge(mtimecmp_q, wdata_i, strobe_i);
      if (sel_msip && strobe_i[0]) msip_d = wdata_i[0];
    end
  end

  always_comb begin
    rdata_o = 64'd0;
    if (sel_msip)       rdata_o = {63'd0, msip_q};
    else if (sel_cmp)   rdata_o = mtimecmp_q;
    else if (sel_mtime) rdata_o = mtime_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q     <= 32'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      trint_q    <= 1'b0;
      swint_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      trint_q    <= (mtime_q >= mtimecmp_q);
      swint_q    <= msip_q;
    end
  end

  assign trint_o = trint_q;
  assign swint_o = swint_q;

endmodule

// File: rtl/cbus_clint.sv
// CBus routing stage: serves the CLINT window locally, forwards everything
// else to memory unchanged, and drives the core's interrupt lines.
module cbus_clint
  import cbus_clint_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  cbus_req_t    ireq,
  output cbus_resp_t   iresp,
  output cbus_req_t    oreq,
  input  cbus_resp_t   oresp,
  input  logic         exint_in,
  output logic         trint,
  output logic         swint,
  output logic         exint,
  output clint_state_t state_o
);

  // Handshake: a request is held with valid=1 until the beat with last=1 is
  // returned; each cycle with ready=1 completes exactly one beat.
  clint_state_t state_q, state_d;
  logic [7:0]   beat_q, beat_d;
  logic         exint_q;
  logic         in_region, last_beat, reg_we;
  logic [63:0]  rdata;

  assign in_region = ((ireq.addr & ~(CLINT_SIZE - 32'd1)) == CLINT_BASE);
  assign last_beat = (beat_q == ireq.len);
  assign reg_we    = (state_q == LOCAL) && ireq.valid && ireq.is_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= 8'd0;
      exint_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      exint_q <= exint_in;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = 8'd0;
        if (ireq.valid) state_d = in_region ? LOCAL : PASS;
      end
      PASS: begin
        if (oresp.ready && oresp.last) state_d = IDLE;
      end
      LOCAL: begin
        if (!ireq.valid || last_beat) state_d = IDLE;
        else beat_d = beat_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oreq  = '0;
    iresp = '0;
    case (state_q)
      PASS: begin
        oreq  = ireq;
        iresp = oresp;
      end
      LOCAL: begin
        iresp.ready = 1'b1;
        iresp.last  = last_beat;
        iresp.data  = rdata;
      end
      default: ;
    endcase
  end

  clint_regs #(
    .TICK_DIV(TICK_DIV)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .we_i    (reg_we),
    .word_i  (ireq.addr[15:3]),
    .strobe_i(ireq.strobe),
    .wdata_i (ireq.data),
    .rdata_o (rdata),
    .trint_o (trint),
    .swint_o (swint)
  );

  assign exint   = exint_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cbus_clint.sv
// Directed bench for cbus_clint with a small register model and a scoreboard
// of expected response data per beat.
module tb_cbus_clint;
  import cbus_clint_pkg::*;

  localparam logic [31:0] A_MSIP = 32'h0200_0000;
  localparam logic [31:0] A_CMP  = 32'h0200_4000;
  localparam logic [31:0] A_MT   = 32'h0200_BFF8;
  localparam logic [31:0] A_HOLE = 32'h0200_0100;
  localparam logic [31:0] A_MEM  = 32'h8000_0000;

  logic         clk, reset, exint_in, trint, swint, exint;
  cbus_req_t    ireq, oreq;
  cbus_resp_t   iresp, oresp;
  clint_state_t state_o;

  logic [63:0] exp_q[$];
  int          n_tests, n_fail, cyc, mt_c0, beats;
  logic [63:0] mt_base, cmp_m, mem_d;
  logic        msip_m;

  cbus_clint dut (
    .clk     (clk),
    .reset   (reset),
    .ireq    (ireq),
    .iresp   (iresp),
    .oreq    (oreq),
    .oresp   (oresp),
    .exint_in(exint_in),
    .trint   (trint),
    .swint   (swint),
    .exint   (exint),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // checks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // register model
  function automatic logic [63:0] mt_at(input int c);
    return mt_base + 64'(c - mt_c0);
  endfunction

  function automatic logic [63:0] rd_model(input logic [31:0] a, input int c);
    case (a[15:0])
      16'h0000: return {63'd0, msip_m};
      16'h4000: return cmp_m;
      16'hBFF8: return mt_at(c);
      default:  return 64'd0;
    endcase
  endfunction

  function automatic void apply_write(input logic [31:0] a, input logic [7:0] strb,
                                      input logic [63:0] d, input int c);
    logic [63:0] cur;
    cur = rd_model(a, c);
    for (int i = 0; i < 8; i++) if (strb[i]) cur[8*i +: 8] = d[8*i +: 8];
    case (a[15:0])
      16'h0000: msip_m = cur[0];
      16'h4000: cmp_m = cur;
      16'hBFF8: begin mt_base = cur; mt_c0 = c + 1; end
      default: ;
    endcase
  endfunction

  function automatic logic trint_model(input int c);
    return (mt_at(c - 1) >= cmp_m);
  endfunction

  function automatic void model_reset();
    mt_base = 64'd0;
    mt_c0   = 0;
    cmp_m   = '1;
    msip_m  = 1'b0;
  endfunction

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic local_txn(input logic we, input logic [31:0] addr, input logic [7:0] strb,
                           input logic [63:0] wdata, input logic [7:0] len, input string tag);
    int nb, budget;
    ireq          = '0;
    ireq.valid    = 1'b1;
    ireq.is_write = we;
    ireq.size     = 3'd3;
    ireq.addr     = addr;
    ireq.strobe   = strb;
    ireq.data     = wdata;
    ireq.len      = len;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(rd_model(addr, cyc + 1 + i));
    nb = 0;
    budget = 0;
    while (nb <= int'(len) && budget < 20) begin
      @(negedge clk);
      budget++;
      if (iresp.ready) begin
        chk({tag, "_data"}, iresp.data, exp_q.pop_front());
        chk1({tag, "_last"}, iresp.last, (nb == int'(len)));
        if (we) apply_write(addr, strb, wdata, cyc);
        nb++;
      end
    end
    if (nb <= int'(len)) begin
      chk({tag, "_beats"}, 64'(nb), 64'(len) + 64'd1);
      exp_q.delete();
    end
    tick();
    ireq = '0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ireq     = '0;
    oresp    = '0;
    exint_in = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_trint", trint, 1'b0);
    chk1("rst_swint", swint, 1'b0);
    chk1("rst_exint", exint, 1'b0);
    chk1("rst_oreq_valid", oreq.valid, 1'b0);
    chk1("rst_iresp_ready", iresp.ready, 1'b0);
    chk("rst_state", 64'(state_o), 64'(IDLE));
    reset = 1'b1;

    // 1: idle after release, mtime counting
    tick();
    @(negedge clk);
    chk1("t1_trint", trint, 1'b0);
    chk1("t1_swint", swint, 1'b0);
    chk1("t1_oreq_valid", oreq.valid, 1'b0);
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd0, "t1_mtime_a");
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd0, "t1_mtime_b");

    // 2: forwarded read
    mem_d       = {$urandom, $urandom};
    ireq        = '0;
    ireq.valid  = 1'b1;
    ireq.size   = 3'd3;
    ireq.addr   = A_MEM;
    ireq.strobe = 8'hFF;
    ireq.burst  = 2'd1;
    ireq.data   = {$urandom, $urandom};
    oresp       = '{ready: 1'b1, last: 1'b1, data: mem_d};
    exp_q.push_back(mem_d);
    @(negedge clk);
    chk1("t2_idle_oreq_valid", oreq.valid, 1'b0);
    beats = 0;
    for (int k = 0; k < 10 && beats == 0; k++) begin
      @(negedge clk);
      if (iresp.ready) begin
        chk("t2_data", iresp.data, exp_q.pop_front());
        chk1("t2_last", iresp.last, 1'b1);
        n_tests++;
        assert (oreq === ireq) else begin
          n_fail++;
          $error("FAIL t2_oreq observed=%h expected=%h", oreq, ireq);
        end
        beats++;
      end
    end
    chk("t2_beats", 64'(beats), 64'd1);
    tick();
    ireq  = '0;
    oresp = '0;
    @(negedge clk);
    chk("t2_state_idle", 64'(state_o), 64'(IDLE));
    chk1("t2_iresp_ready_idle", iresp.ready, 1'b0);
    chk1("t2_oreq_valid_idle", oreq.valid, 1'b0);

    // 3: timer compare
    local_txn(1'b1, A_MT, 8'hFF, 64'd0, 8'd0, "t3_mt_clr");
    local_txn(1'b1, A_CMP, 8'hFF, 64'h20, 8'd0, "t3_cmp");
    for (int k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      chk1("t3_trint", trint, trint_model(cyc));
    end
    local_txn(1'b0, A_CMP, 8'h00, 64'd0, 8'd0, "t3_cmp_rd");
    local_txn(1'b1, A_CMP, 8'hFF, '1, 8'd0, "t3_cmp_max");
    tick();
    @(negedge clk);
    chk1("t3_trint_clear", trint, trint_model(cyc));

    // 4: software interrupt, byte strobes, unmapped offsets
    local_txn(1'b1, A_MSIP, 8'hFF, 64'd1, 8'd0, "t4_msip_set");
    tick();
    @(negedge clk);
    chk1("t4_swint_set", swint, 1'b1);
    local_txn(1'b0, A_MSIP, 8'h00, 64'd0, 8'd0, "t4_msip_rd");
    local_txn(1'b1, A_MSIP, 8'h02, 64'd0, 8'd0, "t4_msip_strb");
    tick();
    @(negedge clk);
    chk1("t4_swint_hold", swint, 1'b1);
    local_txn(1'b1, A_MSIP, 8'hFF, 64'd0, 8'd0, "t4_msip_clr");
    tick();
    @(negedge clk);
    chk1("t4_swint_clr", swint, 1'b0);
    local_txn(1'b1, A_HOLE, 8'hFF, '1, 8'd0, "t4_hole_wr");
    local_txn(1'b0, A_HOLE, 8'h00, 64'd0, 8'd0, "t4_hole_rd");
    local_txn(1'b1, A_CMP, 8'h01, 64'hAB, 8'd0, "t4_cmp_byte");
    local_txn(1'b0, A_CMP, 8'h00, 64'd0, 8'd0, "t4_cmp_byte_rd");

    // 5: mtime wrap and write-over-increment
    local_txn(1'b1, A_MT, 8'hFF, '1, 8'd0, "t5_mt_max");
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      chk1("t5_trint_wrap", trint, trint_model(cyc));
    end
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd0, "t5_mt_wrapped");
    local_txn(1'b1, A_MT, 8'hFF, 64'h1000, 8'd0, "t5_mt_set");
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd0, "t5_mt_held");

    // 6: burst read, then reset mid-burst
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd3, "t6_burst");
    exint_in = 1'b1;
    local_txn(1'b1, A_MSIP, 8'hFF, 64'd1, 8'd0, "t6_msip");
    local_txn(1'b1, A_CMP, 8'hFF, 64'd0, 8'd0, "t6_cmp0");
    tick();
    @(negedge clk);
    chk1("t6_pre_exint", exint, 1'b1);
    chk1("t6_pre_swint", swint, 1'b1);
    chk1("t6_pre_trint", trint, trint_model(cyc));
    tick();
    ireq       = '0;
    ireq.valid = 1'b1;
    ireq.size  = 3'd3;
    ireq.addr  = A_MT;
    ireq.len   = 8'd3;
    for (int i = 0; i < 4; i++) exp_q.push_back(rd_model(A_MT, cyc + 1 + i));
    beats = 0;
    for (int k = 0; k < 10 && beats < 2; k++) begin
      @(negedge clk);
      if (iresp.ready) begin
        chk("t6_abort_data", iresp.data, exp_q.pop_front());
        chk1("t6_abort_last", iresp.last, 1'b0);
        beats++;
      end
    end
    chk("t6_abort_beats", 64'(beats), 64'd2);
    #2;
    reset    = 1'b0;
    exint_in = 1'b0;
    #1;
    chk1("t6_rst_iresp_ready", iresp.ready, 1'b0);
    chk1("t6_rst_iresp_last", iresp.last, 1'b0);
    chk("t6_rst_iresp_data", iresp.data, 64'd0);
    chk1("t6_rst_oreq_valid", oreq.valid, 1'b0);
    chk1("t6_rst_trint", trint, 1'b0);
    chk1("t6_rst_swint", swint, 1'b0);
    chk1("t6_rst_exint", exint, 1'b0);
    chk("t6_rst_state", 64'(state_o), 64'(IDLE));
    exp_q.delete();
    ireq = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    local_txn(1'b0, A_MT, 8'h00, 64'd0, 8'd0, "t6_post_mt");
    local_txn(1'b0, A_CMP, 8'h00, 64'd0, 8'd0, "t6_post_cmp");
    local_txn(1'b0, A_MSIP, 8'h00, 64'd0, 8'd0, "t6_post_msip");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
